// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg -- shared ALUOp, funct and ALU control encodings plus the pipe FSM state type.
// Revision: 1.0
`default_nettype none
package alu_ctrl_pkg;

  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_RTYPE = 2'b10;
  localparam logic [1:0] AOP_SLT   = 2'b11;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_MUL = 6'b011000;

  localparam logic [3:0] CTL_AND     = 4'b0000;
  localparam logic [3:0] CTL_OR      = 4'b0001;
  localparam logic [3:0] CTL_ADD     = 4'b0010;
  localparam logic [3:0] CTL_SUB     = 4'b0110;
  localparam logic [3:0] CTL_SLT     = 4'b0111;
  localparam logic [3:0] CTL_MUL     = 4'b1000;
  localparam logic [3:0] CTL_XOR     = 4'b1001;
  localparam logic [3:0] CTL_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_pipe_if.sv
// alu_ctrl_pipe_if -- upstream/downstream handshake and decode bus of the ALU control pipe.
// Revision: 1.0
`default_nettype none
interface alu_ctrl_pipe_if #(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 2,
  parameter int CTRL_W  = 4
);
  logic               valid_i;
  logic               ready_o;
  logic [FUNCT_W-1:0] funct_i;
  logic [ALUOP_W-1:0] ALUOp_i;
  logic               valid_o;
  logic               ready_i;
  logic [CTRL_W-1:0]  ALUCtrl_o;
  logic               multi_o;
  logic               busy_o;
  logic               illegal_o;
  logic               illegal_clr_i;

  modport slave (
    input  valid_i, funct_i, ALUOp_i, ready_i, illegal_clr_i,
    output ready_o, valid_o, ALUCtrl_o, multi_o, busy_o, illegal_o
  );

  modport master (
    output valid_i, funct_i, ALUOp_i, ready_i, illegal_clr_i,
    input  ready_o, valid_o, ALUCtrl_o, multi_o, busy_o, illegal_o
  );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode -- combinational ALUOp/funct to 4-bit ALU control decode.
// Revision: 1.0
`default_nettype none
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 2
) (
  input  logic [FUNCT_W-1:0] funct,
  input  logic [ALUOP_W-1:0] aluop,
  output logic [3:0]         ctrl,
  output logic               is_mul,
  output logic               is_illegal
);

  always_comb begin
    ctrl = CTL_ILLEGAL;
    case (aluop)
      ALUOP_W'(AOP_ADD): ctrl = CTL_ADD;
      ALUOP_W'(AOP_SUB): ctrl = CTL_SUB;
      ALUOP_W'(AOP_SLT): ctrl = CTL_SLT;
      ALUOP_W'(AOP_RTYPE): begin
        case (funct)
          FUNCT_W'(FN_ADD): ctrl = CTL_ADD;
          FUNCT_W'(FN_SUB): ctrl = CTL_SUB;
          FUNCT_W'(FN_AND): ctrl = CTL_AND;
          FUNCT_W'(FN_OR):  ctrl = CTL_OR;
          FUNCT_W'(FN_SLT): ctrl = CTL_SLT;
          FUNCT_W'(FN_XOR): ctrl = CTL_XOR;
          FUNCT_W'(FN_MUL): ctrl = CTL_MUL;
          default:          ctrl = CTL_ILLEGAL;
        endcase
      end
      default: ctrl = CTL_ILLEGAL;
    endcase
  end

  assign is_mul     = (ctrl == CTL_MUL);
  assign is_illegal = (ctrl == CTL_ILLEGAL);

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe -- one-deep registered ALU control stage with multi-cycle mul hold-off.
// Revision: 1.0
`default_nettype none
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 2,
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_ctrl_pipe_if.slave bus
);

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               valid_q;
  logic [CTRL_W-1:0]  ctrl_q;
  logic               multi_q;
  logic               illegal_q;

  logic [3:0]         dec_ctrl;
  logic               dec_mul;
  logic               dec_illegal;
  logic               ready;
  logic               accept;

  alu_ctrl_decode #(
    .FUNCT_W (FUNCT_W),
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .funct      (bus.funct_i),
    .aluop      (bus.ALUOp_i),
    .ctrl       (dec_ctrl),
    .is_mul     (dec_mul),
    .is_illegal (dec_illegal)
  );

  assign ready  = !rst_i && ((state == ST_EMPTY) || (state == ST_FULL && bus.ready_i));
  assign accept = bus.valid_i && ready;

  // cnt counts WAIT cycles still to go, including the current one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_EMPTY;
      cnt       <= '0;
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      multi_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (bus.illegal_clr_i) illegal_q <= 1'b0;
      if (accept && dec_illegal) illegal_q <= 1'b1;

      case (state)
        ST_EMPTY, ST_FULL: begin
          if (accept) begin
            if (dec_mul && (MUL_LAT > 1)) begin
              state   <= ST_WAIT;
              cnt     <= CNT_W'(MUL_LAT - 1);
              valid_q <= 1'b0;
            end else begin
              state   <= ST_FULL;
              valid_q <= 1'b1;
              ctrl_q  <= CTRL_W'(dec_ctrl);
              multi_q <= dec_mul;
            end
          end else if (state == ST_FULL && bus.ready_i) begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state   <= ST_FULL;
            cnt     <= '0;
            valid_q <= 1'b1;
            ctrl_q  <= CTRL_W'(CTL_MUL);
            multi_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state   <= ST_EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o   = ready;
  assign bus.valid_o   = valid_q;
  assign bus.ALUCtrl_o = ctrl_q;
  assign bus.multi_o   = multi_q;
  assign bus.busy_o    = (state == ST_WAIT);
  assign bus.illegal_o = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_pipe.sv
// tb_alu_ctrl_pipe -- directed and random checks of alu_ctrl_pipe against a cycle-level behavioural model.
// Revision: 1.0
`default_nettype none
module tb_alu_ctrl_pipe;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_ctrl_pipe_if #(.FUNCT_W(6), .ALUOP_W(2), .CTRL_W(4)) bus ();

  alu_ctrl_pipe #(
    .FUNCT_W (6),
    .ALUOP_W (2),
    .CTRL_W  (4),
    .MUL_LAT (LAT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int compared = 0;
  int mismatched = 0;

  // Model: the op currently presented, cycles until a pending mul appears, sticky flag.
  logic       m_valid = 0;
  logic [3:0] m_ctrl  = 0;
  logic       m_multi = 0;
  int         m_wait  = 0;
  logic       m_ill   = 0;

  function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0111;
    case (fn)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      6'b100110: return 4'b1001;
      6'b011000: return 4'b1000;
      default:   return 4'b1111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic [1:0] op, input logic [5:0] fn,
                     input logic rdy, input logic clr, input logic rs);
    logic m_ready, acc, mul;
    logic [3:0] code;
    bus.valid_i = v; bus.ALUOp_i = op; bus.funct_i = fn;
    bus.ready_i = rdy; bus.illegal_clr_i = clr; rst = rs;
    #1;
    m_ready = !rs && ((!m_valid && m_wait == 0) || (m_valid && rdy));
    check("ready_o", {31'b0, bus.ready_o}, {31'b0, m_ready});
    acc  = v && m_ready;
    code = ref_decode(op, fn);
    mul  = (op == 2'b10) && (fn == 6'b011000);
    @(posedge clk);
    #1;
    if (rs) begin
      m_valid = 0; m_ctrl = 0; m_multi = 0; m_wait = 0; m_ill = 0;
    end else begin
      if (clr) m_ill = 0;
      if (acc && code == 4'b1111) m_ill = 1;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin m_valid = 1; m_ctrl = 4'b1000; m_multi = 1; end
      end else if (acc) begin
        if (mul && LAT > 1) begin m_wait = LAT - 1; m_valid = 0; end
        else begin m_valid = 1; m_ctrl = code; m_multi = mul; end
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
    end
    check("valid_o", {31'b0, bus.valid_o}, {31'b0, m_valid});
    check("busy_o", {31'b0, bus.busy_o}, {31'b0, (m_wait != 0)});
    check("illegal_o", {31'b0, bus.illegal_o}, {31'b0, m_ill});
    if (m_valid) begin
      check("ALUCtrl_o", {28'b0, bus.ALUCtrl_o}, {28'b0, m_ctrl});
      check("multi_o", {31'b0, bus.multi_o}, {31'b0, m_multi});
    end else if (m_wait == 0) begin
      check("ALUCtrl_o_hold", {28'b0, bus.ALUCtrl_o}, {28'b0, m_ctrl});
    end
  endtask

  initial begin
    logic [5:0] legal [7];
    legal = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100110, 6'b011000};

    // Reset state.
    cyc(0, 2'b00, 6'h00, 0, 0, 1);
    cyc(0, 2'b00, 6'h00, 0, 0, 1);
    check("rst_multi_o", {31'b0, bus.multi_o}, 32'd0);
    cyc(0, 2'b00, 6'h00, 0, 0, 0);

    // Single R-type sub.
    cyc(1, 2'b10, 6'b100010, 1, 0, 0);
    check("sub_code", {28'b0, bus.ALUCtrl_o}, 32'h6);
    cyc(0, 2'b00, 6'h00, 1, 0, 0);

    // Mul latency.
    cyc(1, 2'b10, 6'b011000, 1, 0, 0);
    for (int i = 0; i < LAT + 1; i++) cyc(0, 2'b00, 6'h00, 1, 0, 0);

    // Back-to-back add/sub/and/or/slt.
    cyc(1, 2'b10, 6'b100000, 1, 0, 0);
    cyc(1, 2'b10, 6'b100010, 1, 0, 0);
    cyc(1, 2'b10, 6'b100100, 1, 0, 0);
    cyc(1, 2'b10, 6'b100101, 1, 0, 0);
    cyc(1, 2'b10, 6'b101010, 1, 0, 0);
    check("slt_code", {28'b0, bus.ALUCtrl_o}, 32'h7);
    cyc(0, 2'b00, 6'h00, 1, 0, 0);

    // Stall with ALUOp=01 held.
    cyc(1, 2'b01, 6'h00, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 2'b01, 6'h00, 0, 0, 0);
    check("stall_code", {28'b0, bus.ALUCtrl_o}, 32'h6);
    cyc(0, 2'b01, 6'h00, 1, 0, 0);

    // Illegal sticky, clear collides with a second illegal accept.
    cyc(1, 2'b10, 6'b111111, 1, 0, 0);
    cyc(0, 2'b00, 6'h00, 1, 0, 0);
    cyc(1, 2'b10, 6'b111111, 1, 1, 0);
    check("ill_sticky", {31'b0, bus.illegal_o}, 32'd1);
    cyc(0, 2'b00, 6'h00, 1, 1, 0);

    // Reset during mul WAIT aborts the op.
    cyc(1, 2'b10, 6'b011000, 1, 0, 0);
    cyc(0, 2'b00, 6'h00, 1, 0, 0);
    cyc(0, 2'b00, 6'h00, 1, 0, 1);
    check("abort_ctrl", {28'b0, bus.ALUCtrl_o}, 32'd0);
    for (int i = 0; i < LAT + 2; i++) cyc(0, 2'b00, 6'h00, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [5:0] fn;
      fn = ($urandom % 4 == 0) ? 6'($urandom) : legal[$urandom % 7];
      cyc(($urandom % 10) < 7, 2'($urandom), fn, ($urandom % 10) < 6,
          ($urandom % 10) == 0, ($urandom % 60) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_pipe.md
ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

Interface
REQ-001 Parameter FUNCT_W, default 6, width of funct_i.
REQ-002 Parameter ALUOP_W, default 2, width of ALUOp_i.
REQ-003 Parameter CTRL_W, default 4, width of ALUCtrl_o; SHALL be >= 4.
REQ-004 Parameter MUL_LAT, default 4, cycles from mul acceptance to valid_o; SHALL be >= 1.
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 clk_i  input  1  clock; all state updates on the rising edge.
REQ-007 rst_i  input  1  synchronous active-high reset.
REQ-008 valid_i  input  1  upstream op valid.
REQ-009 ready_o  output  1  block can accept an op this cycle.
REQ-010 funct_i  input  FUNCT_W  R-type funct field.
REQ-011 ALUOp_i  input  ALUOP_W  main-control ALU op class.
REQ-012 valid_o  output  1  ALUCtrl_o holds a decoded op.
REQ-013 ready_i  input  1  downstream consumes the op when valid_o=1.
REQ-014 ALUCtrl_o  output  CTRL_W  registered ALU control code, zero-extended.
REQ-015 multi_o  output  1  the presented op is multi-cycle (mul).
REQ-016 busy_o  output  1  mul latency counter running.
REQ-017 illegal_o  output  1  sticky: an undefined funct was accepted.
REQ-018 illegal_clr_i  input  1  clears illegal_o.

Function
REQ-019 Decode: ALUOp 00->0010; 01->0110; 11->0111; 10 -> funct 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100110->1001, 011000->1000, other->1111.
REQ-020 Accept = valid_i && ready_o; decode is sampled only on accept.
REQ-021 FSM states: EMPTY, FULL, WAIT; reset state EMPTY.
REQ-022 ready_o = (state==EMPTY) || (state==FULL && ready_i); always 0 in WAIT.
REQ-023 EMPTY/FULL, accept of non-mul op -> FULL next cycle, ALUCtrl_o updated, valid_o=1 (latency 1).
REQ-024 EMPTY/FULL, accept of mul (ALUOp 10, funct 011000) -> WAIT; counter loads MUL_LAT-1; valid_o=0.
REQ-025 WAIT: counter decrements each cycle; at counter==0 -> FULL next cycle with ALUCtrl_o=1000, multi_o=1, valid_o=1; mul presented exactly MUL_LAT cycles after accept.
REQ-026 MUL_LAT=1: mul behaves as REQ-023 with multi_o=1; WAIT is not entered.
REQ-027 FULL, ready_i=1, no accept -> EMPTY; valid_o=0, ALUCtrl_o holds last value.
REQ-028 FULL, ready_i=0 -> FULL; ALUCtrl_o and multi_o stable (no change while stalled).
REQ-029 busy_o = (state==WAIT).
REQ-030 illegal_o sets on the cycle after accepting a 1111 decode; illegal op is still presented as 1111 with normal latency.
REQ-031 illegal_clr_i clears illegal_o next cycle; simultaneous set and clear -> set wins.
REQ-032 Inputs with valid_i=0 SHALL not change any state.

Reset
REQ-033 rst_i=1 on a rising edge -> state EMPTY, counter 0, valid_o=0, ALUCtrl_o=0, multi_o=0, busy_o=0, illegal_o=0.
REQ-034 Reset in WAIT or FULL aborts the op; no output after reset release until a new accept.
REQ-035 ready_o=0 while rst_i=1.

Structure
REQ-036 Shared package alu_ctrl_pkg: ALUOp codes, funct codes, ALU control codes (incl. illegal 1111), FSM state enum.
REQ-037 Combinational sub-module alu_ctrl_decode (funct, ALUOp -> ctrl, is_mul, is_illegal); alu_ctrl_pipe holds the FSM, counter and output registers.

Verification
REQ-038 Reset then ALUOp=10, funct=100010, valid_i=1, ready_i=1 -> next cycle valid_o=1, ALUCtrl_o=0110, multi_o=0.
REQ-039 MUL_LAT=4, accept funct=011000 at cycle 0 -> busy_o=1 and ready_o=0 cycles 1-3; cycle 4 valid_o=1, ALUCtrl_o=1000, multi_o=1.
REQ-040 ready_i=1, valid_i=1 for 5 ops add/sub/and/or/slt -> valid_o=1 for 5 consecutive cycles, codes 0010,0110,0000,0001,0111.
REQ-041 Present ALUOp=01 with ready_i=0 for 3 cycles -> ALUCtrl_o=0110 stable, ready_o=0; ready_i=1 -> EMPTY next cycle.
REQ-042 Accept funct=111111 (ALUOp 10) -> ALUCtrl_o=1111, illegal_o=1 sticky; illegal_clr_i=1 with a second illegal accept the same cycle -> illegal_o stays 1.
REQ-043 rst_i=1 in cycle 2 of a mul WAIT -> next cycle valid_o=0, busy_o=0, ALUCtrl_o=0; no mul output appears later.
